// File: rtl/fifo_sched_pkg.sv
// Shared types and helpers for the round-robin FIFO scheduler.
// Holds the drain-side state encoding and the index-width helper
// used to size producer indices.
package fifo_sched_pkg;

    // One-hot encoding so that any corrupted state is easy to detect
    // and recover from in the default branch.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        WAIT = 3'b010,
        HOLD = 3'b100
    } drain_state_t;

    // Width of a producer index; never narrower than one bit.
    function automatic int index_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_rr_scheduler_arbiter.sv
// Round-robin arbiter owning the priority pointer.
// The search starts at the pointer and wraps. The pointer moves one past
// the winner only when the caller reports that the grant was used.
module rr_arbiter
    import fifo_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDW = index_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_id
);

    logic [IDW-1:0] ptr;

    // First requester at or after the pointer, searching cyclically.
    always_comb begin
        logic           found;
        logic [IDW-1:0] idx;
        found    = 1'b0;
        idx      = '0;
        grant    = '0;
        grant_id = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

    // Priority moves just past the producer that was actually served.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Round-robin push arbitration and valid/ready drain around a shared FIFO.
// The FIFO read data appears one cycle after pop, so the drain side waits
// one cycle between a pop and presenting the word downstream.
// Optional build macro: FIFO_SCHED_OCCUPANCY_EN adds an occupancy output
// that tracks the FIFO fill level.
module fifo_rr_scheduler
    import fifo_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    localparam int IDW = index_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [IDW-1:0]                grant_id,
    output logic                          fifo_push,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    output logic                          fifo_pop,
    input  logic [DATA_WIDTH-1:0]         fifo_data_out,
    input  logic                          fifo_empty,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    input  logic                          out_ready
`ifdef FIFO_SCHED_OCCUPANCY_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy
`endif
);

    if (NUM_REQ < 2 || DEPTH < 1) begin : g_param_check
        $error("fifo_rr_scheduler: NUM_REQ must be >= 2 and DEPTH >= 1");
    end

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDW-1:0]     arb_id;
    drain_state_t       state;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arbiter (
        .clk      (clk),
        .reset    (reset),
        .req      (req_valid),
        .advance  (fifo_push),
        .grant    (arb_grant),
        .grant_id (arb_id)
    );

    // A winner is only accepted when the FIFO has room.
    assign fifo_push = (|arb_grant) && !fifo_full && !reset;
    assign req_ready = fifo_push ? arb_grant : '0;
    assign grant_id  = fifo_push ? arb_id : '0;

    // Route the winning producer's payload to the FIFO.
    always_comb begin
        fifo_data_in = req_data[DATA_WIDTH-1:0];
        for (int i = 1; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Pop from IDLE, or chain the next pop onto a downstream handshake.
    assign fifo_pop = !reset && !fifo_empty &&
                      ((state == IDLE) || ((state == HOLD) && out_ready));

    // Drain sequencer: pop, wait for read data, hold it until accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    out_data  <= fifo_data_out;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= fifo_empty ? IDLE : WAIT;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef FIFO_SCHED_OCCUPANCY_EN
    localparam int OCC_W = $clog2(DEPTH+1);
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

    // Fill level follows pushes and pops; simultaneous ones cancel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occupancy <= '0;
        end else if (fifo_push && !fifo_pop) begin
            occupancy <= occupancy + 1'b1;
        end else if (fifo_pop && !fifo_push) begin
            occupancy <= occupancy - 1'b1;
        end
    end

    a_occ_no_overflow : assert property (@(posedge clk) disable iff (reset)
        (occupancy <= OCC_MAX) && !(fifo_push && !fifo_pop && occupancy == OCC_MAX));
    a_occ_no_underflow : assert property (@(posedge clk) disable iff (reset)
        !(fifo_pop && !fifo_push && occupancy == '0));
`endif

endmodule
